// File: rtl/library_store_multi_if.sv
// Write-side bus of library_store_multi: point stream in, registered SRAM write port and status out.
// master = point-extraction front end, slave = library store.
interface library_store_multi_if #(
   parameter int COORD_W = 5,
   parameter int PT_AW   = 11,
   parameter int ADDR_W  = 20
);
   logic               i_start;
   logic               i_valid;
   logic [COORD_W-1:0] i_x;
   logic [COORD_W-1:0] i_y;
   logic               i_deny;
   logic               i_abort;

   logic               o_we;
   logic               o_hdr;
   logic [COORD_W-1:0] o_x;
   logic [COORD_W-1:0] o_y;
   logic [ADDR_W-1:0]  o_addr;
   logic [PT_AW-1:0]   o_count;
   logic               o_ovf;
   logic               o_done;
   logic               o_busy;
   logic               o_full;

   modport master (
      output i_start, i_valid, i_x, i_y, i_deny, i_abort,
      input  o_we, o_hdr, o_x, o_y, o_addr, o_count, o_ovf, o_done, o_busy, o_full
   );

   modport slave (
      input  i_start, i_valid, i_x, i_y, i_deny, i_abort,
      output o_we, o_hdr, o_x, o_y, o_addr, o_count, o_ovf, o_done, o_busy, o_full
   );
endinterface

// File: rtl/library_store_multi.sv
// Stores a burst of (x,y) points per entry into its own SRAM slot; offset 0 of the slot gets a header word.
// Build option LIBSTORE_NO_OVERWRITE_EN: refuse new entries once every slot holds a header (o_full).
module library_store_multi #(
   parameter int COORD_W = 5,
   parameter int SLOT_N  = 26,
   parameter int SLOT_AW = 5,
   parameter int PT_AW   = 11,
   parameter int ADDR_W  = 20
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   library_store_multi_if.slave bus
);

   localparam logic [PT_AW-1:0]   PT_CAP    = {PT_AW{1'b1}};
   localparam logic [PT_AW-1:0]   PT_ONE    = {{(PT_AW-1){1'b0}}, 1'b1};
   localparam logic [PT_AW-1:0]   PT_ZERO   = {PT_AW{1'b0}};
   localparam logic [SLOT_AW-1:0] SLOT_ONE  = {{(SLOT_AW-1){1'b0}}, 1'b1};
   localparam logic [SLOT_AW-1:0] SLOT_ZERO = {SLOT_AW{1'b0}};
   localparam logic [SLOT_AW-1:0] SLOT_LAST = SLOT_AW'(SLOT_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WORK  = 2'd1,
      ST_CLOSE = 2'd2
   } state_t;

   state_t             r_state;
   logic [SLOT_AW-1:0] r_slot;
   logic [PT_AW-1:0]   r_count;
   logic               r_ovf;
   logic               r_we;
   logic               r_hdr;
   logic               r_done;
   logic               r_busy;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [ADDR_W-1:0]  r_addr;

   logic               w_full;
   logic [PT_AW-1:0]   w_count_inc;
   logic               w_room;

   function automatic logic [SLOT_AW-1:0] slot_next(input logic [SLOT_AW-1:0] slot);
      if (slot == SLOT_LAST) begin
         return SLOT_ZERO;
      end else begin
         return slot + SLOT_ONE;
      end
   endfunction

   function automatic logic [ADDR_W-1:0] make_addr(input logic [SLOT_AW-1:0] slot,
                                                   input logic [PT_AW-1:0]   offset);
      return (ADDR_W'(slot) << PT_AW) | ADDR_W'(offset);
   endfunction

   assign w_count_inc = r_count + PT_ONE;
   assign w_room      = (r_count != PT_CAP);

`ifdef LIBSTORE_NO_OVERWRITE_EN
   localparam int USED_W = $clog2(SLOT_N + 1);
   localparam logic [USED_W-1:0] USED_ONE  = {{(USED_W-1){1'b0}}, 1'b1};
   localparam logic [USED_W-1:0] USED_LAST = USED_W'(SLOT_N - 1);

   logic [USED_W-1:0] r_used;
   logic              r_full;

   // Slot occupancy: one more used slot per header write, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_used <= {USED_W{1'b0}};
         r_full <= 1'b0;
      end else if ((r_state == ST_CLOSE) && !r_full) begin
         r_used <= r_used + USED_ONE;
         r_full <= (r_used == USED_LAST);
      end else begin
         r_used <= r_used;
         r_full <= r_full;
      end
   end

   assign w_full = r_full;
`else
   assign w_full = 1'b0;
`endif

   // Entry FSM; every write-port field is registered here, strobes default low each cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_slot  <= SLOT_ZERO;
         r_count <= PT_ZERO;
         r_ovf   <= 1'b0;
         r_we    <= 1'b0;
         r_hdr   <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_x     <= {COORD_W{1'b0}};
         r_y     <= {COORD_W{1'b0}};
         r_addr  <= {ADDR_W{1'b0}};
      end else begin
         r_we   <= 1'b0;
         r_hdr  <= 1'b0;
         r_done <= 1'b0;
         r_x    <= {COORD_W{1'b0}};
         r_y    <= {COORD_W{1'b0}};
         r_addr <= {ADDR_W{1'b0}};

         case (r_state)
            ST_IDLE: begin
               if (bus.i_start && !w_full) begin
                  r_state <= ST_WORK;
                  r_busy  <= 1'b1;
                  r_count <= PT_ZERO;
                  r_ovf   <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            ST_WORK: begin
               if (bus.i_abort) begin
                  // Abort wins over close and drops any point offered in the same cycle.
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (bus.i_valid && w_room) begin
                     r_count <= w_count_inc;
                     r_we    <= 1'b1;
                     r_x     <= bus.i_x;
                     r_y     <= bus.i_y;
                     r_addr  <= make_addr(r_slot, w_count_inc);
                  end else if (bus.i_valid) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_count <= r_count;
                  end

                  if (!bus.i_deny) begin
                     r_state <= ST_CLOSE;
                  end else begin
                     r_state <= ST_WORK;
                  end
               end
            end

            ST_CLOSE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_we    <= 1'b1;
               r_hdr   <= 1'b1;
               r_done  <= 1'b1;
               r_addr  <= make_addr(r_slot, PT_ZERO);
               r_slot  <= slot_next(r_slot);
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_we    = r_we;
   assign bus.o_hdr   = r_hdr;
   assign bus.o_x     = r_x;
   assign bus.o_y     = r_y;
   assign bus.o_addr  = r_addr;
   assign bus.o_count = r_count;
   assign bus.o_ovf   = r_ovf;
   assign bus.o_done  = r_done;
   assign bus.o_busy  = r_busy;
   assign bus.o_full  = w_full;

endmodule

// File: tb/tb_library_store_multi.sv
// Bench for library_store_multi: directed entry scenarios with random coordinates, checked against
// an entry-level model (expected write list per entry) plus cycle-exact header/done checks.
module tb_library_store_multi;

   localparam int COORD_W = 5;
`ifdef LIBSTORE_NO_OVERWRITE_EN
   localparam int SLOT_N  = 4;
`else
   localparam int SLOT_N  = 26;
`endif
   localparam int SLOT_AW = 5;
   localparam int PT_AW   = 3;
   localparam int ADDR_W  = 20;
   localparam int CAP     = (1 << PT_AW) - 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic               hdr;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [PT_AW-1:0]   cnt;
      logic               ovf;
      logic               done;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   library_store_multi_if #(.COORD_W(COORD_W), .PT_AW(PT_AW), .ADDR_W(ADDR_W)) bus ();

   library_store_multi #(
      .COORD_W(COORD_W), .SLOT_N(SLOT_N), .SLOT_AW(SLOT_AW), .PT_AW(PT_AW), .ADDR_W(ADDR_W)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   int  n_cmp = 0;
   int  n_bad = 0;
   int  stray = 0;
   wr_t got_q[$];
   wr_t exp_q[$];
   int  m_slot = 0;
   int  m_used = 0;
   bit  m_full = 1'b0;

   function automatic wr_t mk(input int slot, input int off, input bit hdr,
                              input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                              input int cnt, input bit ovf, input bit done);
      wr_t w;
      w.addr = ADDR_W'(slot * (1 << PT_AW) + off);
      w.hdr  = hdr;
      w.x    = x;
      w.y    = y;
      w.cnt  = PT_AW'(cnt);
      w.ovf  = ovf;
      w.done = done;
      return w;
   endfunction

   // Capture every write; outside writes the data/header/done fields must be idle.
   always @(negedge clk) begin
      if (bus.o_we === 1'b1) begin
         got_q.push_back(mk(int'(bus.o_addr) / (1 << PT_AW), int'(bus.o_addr) % (1 << PT_AW),
                            bus.o_hdr, bus.o_x, bus.o_y, int'(bus.o_count), bus.o_ovf, bus.o_done));
      end else if (bus.o_hdr === 1'b1 || bus.o_done === 1'b1 || bus.o_x !== 5'd0 || bus.o_y !== 5'd0) begin
         stray++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic flush_check(input string tag);
      check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      check(tag, {bus.o_we, bus.o_hdr, bus.o_x, bus.o_y, bus.o_addr, bus.o_count,
                  bus.o_ovf, bus.o_done, bus.o_busy, bus.o_full}, 64'd0);
   endtask

   task automatic model_reset();
      m_slot = 0;
      m_used = 0;
      m_full = 1'b0;
   endtask

   // One entry: n points (random gaps), optional abort at point index abort_at, optional close on last point.
   task automatic entry(input int n, input int abort_at, input bit last_close, input bit fixed);
      bit started;
      bit aborted;
      bit closed;
      int kept;
      logic [COORD_W-1:0] xv;
      logic [COORD_W-1:0] yv;
      started = !m_full;
      aborted = 1'b0;
      closed  = 1'b0;
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      bus.i_deny  = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_x     = COORD_W'($urandom);
      bus.i_y     = COORD_W'($urandom);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      check("busy_open", bus.o_busy, started);
      for (int k = 0; k < n && !aborted && !closed; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            bus.i_start = 1'b0;
         end
         xv = fixed ? COORD_W'(2 * k + 1) : COORD_W'($urandom);
         yv = fixed ? COORD_W'(2 * k + 2) : COORD_W'($urandom);
         bus.i_valid = 1'b1;
         bus.i_x     = xv;
         bus.i_y     = yv;
         if (k == abort_at) begin
            bus.i_abort = 1'b1;
            bus.i_deny  = 1'b0;
            aborted     = 1'b1;
         end else begin
            if (last_close && k == n - 1) begin
               bus.i_deny = 1'b0;
               closed     = 1'b1;
            end
            if (started && k < CAP) exp_q.push_back(mk(m_slot, k + 1, 1'b0, xv, yv, k + 1, 1'b0, 1'b0));
         end
         @(posedge clk); #1;
         bus.i_start = 1'b0;
         bus.i_valid = 1'b0;
         bus.i_abort = 1'b0;
         bus.i_deny  = 1'b1;
      end
      if (!aborted && !closed) begin
         bus.i_deny = 1'b0;
         @(posedge clk); #1;
         bus.i_deny  = 1'b1;
         bus.i_start = 1'b0;
      end
      if (started && !aborted) begin
         kept = (n < CAP) ? n : CAP;
         check("done_early", bus.o_done, 1'b0);
         @(posedge clk); #1;
         check("hdr_strobe", {bus.o_we, bus.o_hdr, bus.o_done}, 3'b111);
         check("hdr_count", bus.o_count, kept);
         check("hdr_ovf", bus.o_ovf, n > CAP);
         exp_q.push_back(mk(m_slot, 0, 1'b1, 5'd0, 5'd0, kept, n > CAP, 1'b1));
         m_slot = (m_slot + 1) % SLOT_N;
`ifdef LIBSTORE_NO_OVERWRITE_EN
         m_used++;
         if (m_used == SLOT_N) m_full = 1'b1;
`endif
         @(posedge clk); #1;
         check("done_pulse", bus.o_done, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      check("busy_idle", bus.o_busy, 1'b0);
      check("full", bus.o_full, m_full);
      flush_check("entry");
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_x     = 5'd0;
      bus.i_y     = 5'd0;
      bus.i_deny  = 1'b1;
      bus.i_abort = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst_n = 1'b1;
      model_reset();

      // (1,2),(3,4),(5,6) into slot 0, then header at 0x00000 with count 3
      entry(3, -1, 1'b0, 1'b1);
      entry(9, -1, 1'b0, 1'b0);
      entry(4, -1, 1'b1, 1'b0);
      entry(0, -1, 1'b0, 1'b0);
      entry(5, 2, 1'b0, 1'b0);
      entry(1, -1, 1'b0, 1'b0);
      entry(6, 0, 1'b0, 1'b0);

      // Reset in the middle of an entry: no header, everything back to zero, slot 0 again.
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_x     = 5'd7;
      bus.i_y     = 5'd9;
      if (!m_full) exp_q.push_back(mk(m_slot, 1, 1'b0, 5'd7, 5'd9, 1, 1'b0, 1'b0));
      @(posedge clk); #1;
      bus.i_x = 5'd30;
      bus.i_y = 5'd17;
      if (!m_full) exp_q.push_back(mk(m_slot, 2, 1'b0, 5'd30, 5'd17, 2, 1'b0, 1'b0));
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      rst_n       = 1'b0;
      @(posedge clk); #1;
      check_zero("reset_mid_entry");
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      flush_check("reset_mid");
      entry(1, -1, 1'b0, 1'b0);

      // Back-to-back single-point entries across the slot wrap (or into full).
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      repeat (SLOT_N + 1) entry(1, -1, 1'b0, 1'b0);

      // Random entries.
      for (int r = 0; r < 20; r++) begin
         int n;
         int ab;
         n  = $urandom_range(0, 10);
         ab = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         entry(n, ab, ($urandom_range(0, 1) == 1), 1'b0);
      end

      check("stray_idle_outputs", stray, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
